ciphertext_output_serializer: RTL and testbench
===============================================

Name: ciphertext_output_serializer

Overview:
- Downstream neighbour of the pipelined AES encryptor (cipher_text_generation).
- Captures every 128-bit ciphertext block that the encryptor marks valid, and buffers it in a small block FIFO.
- Emits each buffered block as four 32-bit words on a valid/ready stream toward the bus or host interface.
- Absorbs the encryptor's one-block-per-cycle burst rate, since the encryptor pipeline has no backpressure.

Parameters:
- DEPTH, 4, number of 128-bit blocks buffered; power of two, minimum 2.
- WORD_W, 32, output word width; fixed at 32 in this revision, giving 4 words per block.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ct_in  input  128  ciphertext block from the encryptor's ciphertext output.
- ct_valid  input  1  driven by the encryptor's valid_output; a block is offered in every cycle it is high.
- out_word  output  32  current output word.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  downstream accepts out_word.
- out_last  output  1  out_word is the final (4th) word of its block.
- fifo_count  output  $clog2(DEPTH)+1  number of blocks held, including the block currently being serialized.
- overflow  output  1  sticky flag: a block was dropped because the FIFO was full.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset low, asynchronous): wr_ptr, rd_ptr, fifo_count and word index clear to 0; out_valid=0, out_last=0, overflow=0, out_word=0. Stored block contents need no reset.
- Push: on an edge with ct_valid=1, ct_in is written at wr_ptr if the FIFO is not full, or if the current cycle pops the head block. Otherwise the block is dropped and overflow sets.
- Pointers are modulo DEPTH, with natural wrap-around.
- Word transfer: occurs on a rising edge where out_valid=1 and out_ready=1.
- Word order within a block is MSW first: index 0 = bits [127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0].
- Serializer state: word index 0..3. It advances by one per transfer. On the transfer of index 3, the index returns to 0 and the head block is popped (rd_ptr+1).
- Output signals:
  - out_valid = (fifo_count != 0).
  - out_word = head block sliced by index; combinational from registered state only, no combinational path from ct_in.
  - out_last = out_valid && index==3.
- Latency: a block pushed at edge N appears on out_word in the cycle after edge N when the FIFO was empty. Minimum 4 cycles per block out.
- Stability: while out_valid=1 and out_ready=0, out_word and out_last hold constant. out_valid never drops without a transfer.
- Simultaneous push and pop: fifo_count is unchanged. This holds when full, so a full FIFO accepts a push in the cycle its last word transfers.
- Push into an empty FIFO: out_valid rises the next cycle. The word index is already 0.
- overflow: sets on any dropped block and stays set until overflow_clr=1 at a clock edge.
  - If a drop and overflow_clr occur in the same cycle, set wins.
- Mid-block reset: the partially serialized block is discarded. After reset is released, output resumes only with newly pushed blocks.
- fifo_count never exceeds DEPTH.

Optional Feature:
- Macro: CT_OUT_BLOCK_CNT_EN.
- When defined:
  - Adds output blocks_out, 16 bits.
  - Counts fully emitted blocks, incrementing on each out_last transfer.
  - Wraps 16'hFFFF to 0.
  - Cleared by reset.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - BLOCK_W = 128 and WORDS_PER_BLOCK = 4;
  - a typedef for the 128-bit block and one for the 2-bit word index;
  - the word-slice function, shared with any future upstream packer.
- One natural sub-module: ct_block_fifo. It is a parameterized DEPTH x 128 synchronous FIFO with push, pop, full, empty and count outputs. The top level adds the word-index counter, output mux, overflow flag and optional counter.

Test Plan:
- FIPS-197 block: push 3925841d02dc09fbdc118597196a0b32 with out_ready=1.
  - Expect words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles, with out_last only on 196a0b32.
  - Then fifo_count returns to 0.
- Backpressure: push 66e94bd4ef8a2c3b884cfa59ca342b2e and hold out_ready=0 for 3 cycles.
  - out_word stays 66e94bd4 with out_valid=1 throughout.
  - After releasing out_ready, the remaining words follow in order.
- Overflow (DEPTH=4): with out_ready=0, push 5 distinct blocks on consecutive cycles.
  - Expect fifo_count=4 and overflow=1.
  - Draining yields exactly the first 4 blocks, in order.
  - overflow_clr=1 then clears overflow.
- Full with simultaneous pop: start with the FIFO full and out_ready=1, and push a block in the cycle the head's index-3 word transfers.
  - The push is accepted, overflow stays 0, and fifo_count stays 4.
- Mid-block reset: pull reset low while index=2.
  - out_valid, out_last and fifo_count go to 0 immediately, without waiting for a clock.
  - After release, push f3eed1bdb5d2a03c064b5a7e3db181f8; the first word out is f3eed1bd.
- With CT_OUT_BLOCK_CNT_EN defined: emit 3 complete blocks and expect blocks_out=3. Preload the counter to FFFF, emit one more block, and expect 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES block definitions: block/word-index types and the word-slice helper
// used by the ciphertext serializer and any future upstream packer.
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [1:0]         word_idx_t;

    // Index 0 is the most significant word.
    function automatic logic [31:0] word_slice(input block_t blk, input word_idx_t idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ct_block_fifo.sv
// DEPTH x 128-bit synchronous block FIFO; head is the block at rd_ptr.
// A push into a full FIFO is accepted only when the same cycle pops.
module ct_block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  block_t                 din,
    output block_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    block_t        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Block storage carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ciphertext_output_serializer.sv
// Buffers encryptor ciphertext blocks and streams them as MSW-first 32-bit words.
// Optional CT_OUT_BLOCK_CNT_EN adds a 16-bit count of fully emitted blocks.
module ciphertext_output_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  block_t                 ct_in,
    input  logic                   ct_valid,
    output logic [WORD_W-1:0]      out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
`ifdef CT_OUT_BLOCK_CNT_EN
    input  logic                   overflow_clr,
    output logic [15:0]            blocks_out
`else
    input  logic                   overflow_clr
`endif
);

    block_t    head;
    logic      full;
    logic      empty;
    logic      xfer;
    logic      pop;
    logic      drop;
    word_idx_t idx;

    assign out_valid = !empty;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (idx == 2'd3);
    assign drop      = ct_valid && full && !pop;
    assign out_last  = out_valid && (idx == 2'd3);
    assign out_word  = out_valid ? word_slice(head, idx) : '0;

    ct_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ct_valid),
        .pop   (pop),
        .din   (ct_in),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Index wraps 3 -> 0 on the same transfer that pops the head block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef CT_OUT_BLOCK_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blocks_out <= '0;
        end else if (pop) begin
            blocks_out <= blocks_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ciphertext_output_serializer.sv
// Directed bench for ciphertext_output_serializer: vector table plus corner sequences.
module tb_ciphertext_output_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] ct_in;
    logic         ct_valid;
    logic [31:0]  out_word;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [2:0]   fifo_count;
    logic         overflow;
    logic         overflow_clr;
`ifdef CT_OUT_BLOCK_CNT_EN
    logic [15:0]  blocks_out;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [127:0]      blk;
        logic [3:0][31:0]  w;
    } vec_t;

    vec_t vecs [4];
    logic [31:0] ow [4][4];
    logic [127:0] ob [4];
    logic [31:0] nw [4];
    logic [127:0] nblk;

    ciphertext_output_serializer #(.DEPTH(4), .WORD_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ct_in        (ct_in),
        .ct_valid     (ct_valid),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
`ifdef CT_OUT_BLOCK_CNT_EN
        .overflow_clr (overflow_clr),
        .blocks_out   (blocks_out)
`else
        .overflow_clr (overflow_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.blk  = {w0, w1, w2, w3};
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        return v;
    endfunction

    task automatic push_one(input logic [127:0] blk);
        ct_in    = blk;
        ct_valid = 1'b1;
        step();
        ct_valid = 1'b0;
    endtask

    // Checks one word in the current cycle, then lets it transfer (out_ready must be 1).
    task automatic expect_word(input string name, input logic [31:0] w, input logic last);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_word"}, out_word, w);
        chk({name, "_last"}, out_last, last);
        step();
    endtask

    initial begin
        vecs[0] = mk(32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);
        vecs[1] = mk(32'h66e94bd4, 32'hef8a2c3b, 32'h884cfa59, 32'hca342b2e);
        vecs[2] = mk(32'hf3eed1bd, 32'hb5d2a03c, 32'h064b5a7e, 32'h3db181f8);
        vecs[3] = mk(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        for (int b = 0; b < 4; b++) begin
            ow[b][0] = 32'h10000000 + b;
            ow[b][1] = 32'h20000000 + b;
            ow[b][2] = 32'h30000000 + b;
            ow[b][3] = 32'h40000000 + b;
            ob[b]    = {ow[b][0], ow[b][1], ow[b][2], ow[b][3]};
        end
        nw[0] = 32'hdeadbeef; nw[1] = 32'hcafef00d; nw[2] = 32'h01234567; nw[3] = 32'h89abcdef;
        nblk  = {nw[0], nw[1], nw[2], nw[3]};

        reset = 1'b0; ct_in = '0; ct_valid = 1'b0; out_ready = 1'b1; overflow_clr = 1'b0;
        step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_word", out_word, 32'h0);
        reset = 1'b1;
        step();

        // Table: each block streams out on 4 consecutive cycles with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            push_one(vecs[i].blk);
            for (int w = 0; w < 4; w++)
                expect_word($sformatf("vec%0d_w%0d", i, w), vecs[i].w[w], w == 3);
            chk($sformatf("vec%0d_cnt", i), fifo_count, 3'd0);
            chk($sformatf("vec%0d_empty", i), out_valid, 1'b0);
        end

        // Backpressure holds the first word.
        out_ready = 1'b0;
        push_one(vecs[1].blk);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_word", out_word, 32'h66e94bd4);
            chk("bp_hold_last", out_last, 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) expect_word("bp", vecs[1].w[w], w == 3);
        chk("bp_cnt", fifo_count, 3'd0);

        // Overflow: fifth block is dropped.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_one(ob[b]);
        push_one(nblk);
        chk("ovf_cnt", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 4; w++)
                expect_word($sformatf("ovf_b%0d_w%0d", b, w), ow[b][w], w == 3);
        chk("ovf_drained", fifo_count, 3'd0);
        chk("ovf_sticky", overflow, 1'b1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO accepts a push in the cycle its head's last word transfers.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_one(ob[b]);
        chk("fp_full", fifo_count, 3'd4);
        out_ready = 1'b1;
        step(); step(); step();
        chk("fp_last", out_last, 1'b1);
        ct_in = nblk; ct_valid = 1'b1;
        step();
        ct_valid = 1'b0;
        chk("fp_cnt", fifo_count, 3'd4);
        chk("fp_ovf", overflow, 1'b0);
        for (int b = 1; b < 4; b++)
            for (int w = 0; w < 4; w++)
                expect_word($sformatf("fp_b%0d_w%0d", b, w), ow[b][w], w == 3);
        for (int w = 0; w < 4; w++) expect_word($sformatf("fp_new_w%0d", w), nw[w], w == 3);
        chk("fp_drained", fifo_count, 3'd0);

        // Mid-block reset is asynchronous and discards the partial block.
        push_one(vecs[3].blk);
        step(); step();
        out_ready = 1'b0;
        chk("mr_idx2", out_word, 32'h8899aabb);
        reset = 1'b0;
        #1;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_last", out_last, 1'b0);
        chk("mr_cnt", fifo_count, 3'd0);
        step();
        reset = 1'b1;
        step();
        chk("mr_idle", out_valid, 1'b0);
        out_ready = 1'b1;
        push_one(vecs[2].blk);
        for (int w = 0; w < 4; w++) expect_word($sformatf("mr_w%0d", w), vecs[2].w[w], w == 3);

`ifdef CT_OUT_BLOCK_CNT_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_one(vecs[i].blk);
            step(); step(); step(); step();
        end
        chk("bc_three", blocks_out, 16'd3);
        force dut.blocks_out = 16'hffff;
        #1;
        release dut.blocks_out;
        push_one(vecs[3].blk);
        step(); step(); step(); step();
        chk("bc_wrap", blocks_out, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
